// File: rtl/filter_pkg.sv
// Shared definitions for the greyscale image filter chain: pixel type,
// kernel-sum width and the 3x3 Gaussian weights used by the blur stage.
package filter_pkg;

    localparam int PIX_W  = 8;
    localparam int KSUM_W = 12;

    // 3x3 Gaussian weights [1 2 1; 2 4 2; 1 2 1], total weight 16
    localparam logic [KSUM_W-1:0] K_CORNER = 12'd1;
    localparam logic [KSUM_W-1:0] K_EDGE   = 12'd2;
    localparam logic [KSUM_W-1:0] K_CENTRE = 12'd4;

    typedef logic [PIX_W-1:0] pixel_t;

    // Weighted 3x3 sum; win[row][col], row 0 is the oldest line, col 0 the oldest column.
    // Worst case 255 * 16 = 4080 fits the 12-bit result exactly.
    function automatic logic [KSUM_W-1:0] kernel_sum(input pixel_t [2:0][2:0] win);
        logic [KSUM_W-1:0] acc;
        acc = KSUM_W'(win[0][0]) * K_CORNER + KSUM_W'(win[0][1]) * K_EDGE   + KSUM_W'(win[0][2]) * K_CORNER
            + KSUM_W'(win[1][0]) * K_EDGE   + KSUM_W'(win[1][1]) * K_CENTRE + KSUM_W'(win[1][2]) * K_EDGE
            + KSUM_W'(win[2][0]) * K_CORNER + KSUM_W'(win[2][1]) * K_EDGE   + KSUM_W'(win[2][2]) * K_CORNER;
        return acc;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port read-first line store. The read is combinational so the old
// contents at addr are visible in the same cycle that a write replaces them.
// Contents are deliberately not reset; consumers mask stale rows.
module line_buffer
    import filter_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [PIX_W-1:0]  din,
    output logic [PIX_W-1:0]  dout
);

    pixel_t mem [DEPTH];

    // Read port: current contents at addr (pre-write value on a write cycle)
    always_comb begin
        dout = mem[addr];
    end

    // Write port: store the incoming pixel at addr
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/grey_blur3x3.sv
// 3x3 Gaussian blur for an 8-bit greyscale stream. Two line buffers hold the
// previous two lines; a 3x3 window feeds an adder tree. Output is the input
// valid delayed by two clocks, for centre (row-1, col-1), zero on borders.
module grey_blur3x3
    import filter_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int COL_W      = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VSync,
    input  logic             HSync,
    input  logic             PixValid,
    input  logic [PIX_W-1:0] GryIn,
    output logic [PIX_W-1:0] GryOut,
    output logic             OutValid
);

    // One extra bit so the column can saturate at LINE_WIDTH itself
    localparam int               CNT_W = COL_W + 1;
    localparam logic [CNT_W-1:0] LW_C  = CNT_W'(LINE_WIDTH);

    logic                  r_vs;
    logic                  r_hs;
    logic [CNT_W-1:0]      r_col;
    logic [1:0]            r_row;
    pixel_t [2:0][2:0]     r_win;
    logic                  r_v1;
    logic                  r_b1;
    pixel_t                r_gry;
    logic                  r_ov;

    logic                  w_vs_rise;
    logic                  w_hs_rise;
    logic [CNT_W-1:0]      w_col_eff;
    logic [1:0]            w_row_eff;
    logic                  w_in_range;
    logic                  w_we;
    logic                  w_border;
    logic [COL_W-1:0]      w_addr;
    pixel_t                w_lb1_rd;
    pixel_t                w_lb2_rd;
    logic [KSUM_W-1:0]     w_sum;

    // Position of this cycle's pixel: sync edges apply before the pixel is counted
    always_comb begin
        w_vs_rise = VSync & ~r_vs;
        w_hs_rise = HSync & ~r_hs;
        if (w_vs_rise || w_hs_rise) begin
            w_col_eff = '0;
        end else begin
            w_col_eff = r_col;
        end
        if (w_vs_rise) begin
            w_row_eff = 2'd0;
        end else if (w_hs_rise && (r_col != '0) && (r_row != 2'd3)) begin
            w_row_eff = r_row + 2'd1;
        end else begin
            w_row_eff = r_row;
        end
        w_in_range = (w_col_eff < LW_C);
        w_we       = PixValid & w_in_range & ~RST;
        if (w_in_range) begin
            w_addr = w_col_eff[COL_W-1:0];
        end else begin
            w_addr = '0;
        end
        w_border = (w_row_eff < 2'd2) || (w_col_eff < CNT_W'(2)) || !w_in_range;
    end

    // Sync history and row/column counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vs  <= 1'b0;
            r_hs  <= 1'b0;
            r_col <= '0;
            r_row <= 2'd0;
        end else begin
            r_vs  <= VSync;
            r_hs  <= HSync;
            r_row <= w_row_eff;
            if (PixValid && w_in_range) begin
                r_col <= w_col_eff + CNT_W'(1);
            end else begin
                r_col <= w_col_eff;
            end
        end
    end

    // LB1 holds the previous line; LB2 receives what LB1 held at the same column
    line_buffer #(.DEPTH(LINE_WIDTH), .ADDR_W(COL_W)) u_lb1 (
        .clk  (CLK),
        .addr (w_addr),
        .we   (w_we),
        .din  (GryIn),
        .dout (w_lb1_rd)
    );

    line_buffer #(.DEPTH(LINE_WIDTH), .ADDR_W(COL_W)) u_lb2 (
        .clk  (CLK),
        .addr (w_addr),
        .we   (w_we),
        .din  (w_lb1_rd),
        .dout (w_lb2_rd)
    );

    // Stage 1: shift the window left and capture the border flag for this pixel
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_win <= '0;
            r_v1  <= 1'b0;
            r_b1  <= 1'b0;
        end else begin
            r_v1 <= PixValid;
            if (PixValid) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb2_rd;
                r_win[1][2] <= w_lb1_rd;
                r_win[2][2] <= GryIn;
                r_b1        <= w_border;
            end
        end
    end

    // Adder tree over the current window
    always_comb begin
        w_sum = kernel_sum(r_win);
    end

    // Stage 2: truncate the sum to 8 bits (divide by 16) or force zero on borders
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gry <= '0;
            r_ov  <= 1'b0;
        end else begin
            r_ov <= r_v1;
            if (r_v1) begin
                r_gry <= r_b1 ? '0 : PIX_W'(w_sum >> 4);
            end
        end
    end

    assign GryOut   = r_gry;
    assign OutValid = r_ov;

endmodule

// File: tb/tb_grey_blur3x3.sv
// Randomized self-checking bench for grey_blur3x3 with an image-level
// reference: each accepted pixel (r,c) predicts the blur of the 3x3
// neighbourhood ending at (r,c), or zero on rows/cols < 2 and overflow.
module tb_grey_blur3x3;

    localparam int LW = 8;
    localparam int CW = 3;
    localparam int NR = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       VSync;
    logic       HSync;
    logic       PixValid;
    logic [7:0] GryIn;
    logic [7:0] GryOut;
    logic       OutValid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_out    = 0;

    int img     [0:15][0:15];
    int out_img [0:15][0:15];
    int ref_img [0:15][0:15];

    typedef struct {
        int val;
        int cyc;
        int r;
        int c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    grey_blur3x3 #(.LINE_WIDTH(LW), .COL_W(CW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .VSync    (VSync),
        .HSync    (HSync),
        .PixValid (PixValid),
        .GryIn    (GryIn),
        .GryOut   (GryOut),
        .OutValid (OutValid)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: Gaussian blur of the neighbourhood whose bottom-right is (r,c)
    function automatic int model_px(input int r, input int c);
        int s;
        s = 0;
        if (r < 2 || c < 2 || c >= LW) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += img[r-2+i][c-2+j] * ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1);
        return s / 16;
    endfunction

    // Output monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (OutValid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_outvalid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("pixel", int'(GryOut), mon_e.val);
                check_val("latency", cyc, mon_e.cyc);
                out_img[mon_e.r][mon_e.c] = int'(GryOut);
                n_out++;
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            check_val("missing_outvalid", cyc, mon_e.cyc);
        end
    end

    task automatic drive(input logic vs, input logic hs, input logic pv, input int pix);
        VSync    = vs;
        HSync    = hs;
        PixValid = pv;
        GryIn    = 8'(pix);
        @(posedge CLK);
        #1;
    endtask

    task automatic send_pix(input int r, input int c, input logic vs, input logic hs, input int bub);
        exp_t e;
        int nb;
        nb = 0;
        while (bub > 0 && nb < 8 && int'($urandom_range(99)) < bub) begin
            drive(1'b0, 1'b0, 1'b0, int'($urandom_range(255)));
            nb++;
        end
        e.val = model_px(r, c);
        e.cyc = cyc + 2;
        e.r   = r;
        e.c   = c;
        exp_q.push_back(e);
        drive(vs, hs, 1'b1, img[r][c]);
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        VSync    = 1'b0;
        HSync    = 1'b0;
        PixValid = 1'b0;
        GryIn    = 8'd0;
        // anything due at or after the reset edge is discarded
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= cyc + 1) void'(exp_q.pop_back());
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_val("rst_outvalid", int'(OutValid), 0);
        check_val("rst_gryout", int'(GryOut), 0);
    endtask

    // Even rows: HSync edge coincides with pixel 0; odd rows: separate sync pulse
    task automatic send_frame(input int bub, input int ovf_row, input int rst_row, input int rst_col);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                out_img[r][c] = -1;
        n_out = 0;
        for (int r = 0; r < NR; r++) begin
            int len;
            len = (r == ovf_row) ? LW + 3 : LW;
            if (r % 2 == 1) drive(1'b0, 1'b1, 1'b0, 0);
            for (int c = 0; c < len; c++) begin
                if (r == rst_row && c == rst_col) begin
                    do_reset();
                    return;
                end
                send_pix(r, c, (r == 0 && c == 0), (r % 2 == 0 && c == 0), bub);
            end
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                case (kind)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (r == 5 && c == 5) ? 160 : 0;
                    2:       img[r][c] = 255;
                    default: img[r][c] = int'($urandom_range(255));
                endcase
    endtask

    task automatic save_ref();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < LW; c++)
                ref_img[r][c] = out_img[r][c];
    endtask

    task automatic compare_ref(input string tag);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < LW; c++)
                check_val(tag, out_img[r][c], ref_img[r][c]);
    endtask

    initial begin
        RST = 1'b1; VSync = 1'b0; HSync = 1'b0; PixValid = 1'b0; GryIn = 8'd0;
        @(posedge CLK);
        #1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 0);
        check_val("reset_outvalid", int'(OutValid), 0);
        check_val("reset_gryout", int'(GryOut), 0);
        RST = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 0);

        // flat frame, gapless then with bubbles
        fill(0);
        send_frame(0, -1, -1, -1);
        check_val("flat_interior", out_img[4][4], 100);
        check_val("flat_interior_edge", out_img[7][7], 100);
        check_val("flat_border_row", out_img[1][5], 0);
        check_val("flat_border_col", out_img[5][1], 0);
        check_val("flat_count", n_out, NR * LW);
        save_ref();
        send_frame(50, -1, -1, -1);
        compare_ref("flat_bubble_eq");

        // impulse: centre (r-1,c-1) is reported from input (r,c)
        fill(1);
        send_frame(0, -1, -1, -1);
        check_val("imp_centre", out_img[6][6], 40);
        check_val("imp_up", out_img[5][6], 20);
        check_val("imp_left", out_img[6][5], 20);
        check_val("imp_down", out_img[7][6], 20);
        check_val("imp_right", out_img[6][7], 20);
        check_val("imp_diag_ul", out_img[5][5], 10);
        check_val("imp_diag_ur", out_img[5][7], 10);
        check_val("imp_diag_dl", out_img[7][5], 10);
        check_val("imp_diag_dr", out_img[7][7], 10);
        check_val("imp_far", out_img[3][3], 0);
        save_ref();
        send_frame(50, -1, -1, -1);
        compare_ref("imp_bubble_eq");

        // saturation
        fill(2);
        send_frame(0, -1, -1, -1);
        check_val("sat_interior", out_img[4][4], 255);

        // overflow line on row 3, following rows must still blur correctly
        fill(3);
        send_frame(0, 3, -1, -1);
        check_val("ovf_extra0", out_img[3][LW], 0);
        check_val("ovf_extra1", out_img[3][LW+1], 0);
        check_val("ovf_extra2", out_img[3][LW+2], 0);
        check_val("ovf_count", n_out, NR * LW + 3);
        check_val("ovf_next_row", out_img[4][4], model_px(4, 4));

        // random frame with bubbles
        fill(3);
        send_frame(30, -1, -1, -1);

        // reset in the middle of row 4, then a fresh random frame
        fill(3);
        send_frame(20, -1, 4, 3);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 0);
        fill(3);
        send_frame(40, -1, -1, -1);
        check_val("post_rst_row0", out_img[0][5], 0);
        check_val("post_rst_row1", out_img[1][5], 0);
        check_val("post_rst_blur", out_img[5][5], model_px(5, 5));

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) drive(1'b0, 1'b0, 1'b0, 0);
        check_val("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/grey_blur3x3.md
# grey_blur3x3

3x3 Gaussian blur stage for the 8-bit greyscale pixel stream in the image filter chain, occupying the blur slot between the first threshold and the second threshold. Each clock it accepts at most one pixel, keeps two previous lines in line buffers and produces one blurred pixel per accepted pixel. The output is a fixed two-clock delayed stream, spatially offset by one row and one column.

## Interface
Parameters:
- LINE_WIDTH, 640: maximum active pixels per line, which is also the line buffer depth.
- COL_W, 10: column counter width, ceil(log2(LINE_WIDTH)).

Ports:
- CLK  in  1  pixel clock.
- RST  in  1  reset; synchronous, active-high.
- VSync  in  1  frame sync; a rising edge starts a new frame.
- HSync  in  1  line sync; a rising edge starts a new line.
- PixValid  in  1  GryIn carries an active pixel this cycle.
- GryIn  in  8  greyscale pixel.
- GryOut  out  8  blurred pixel.
- OutValid  out  1  GryOut is valid this cycle.

## Operation
- **Sync edges:** detected against a registered copy of each sync input.
- **Column counter (col):**
  - Cleared on an HSync rising edge.
  - Increments per PixValid.
  - Saturates at LINE_WIDTH.
- **Row counter (row):**
  - Cleared on a VSync rising edge.
  - Increments on an HSync rising edge only if the previous line had at least one pixel.
  - Saturates at 3.
- **Same-cycle priority:** a sync edge takes effect before a PixValid in the same cycle. That pixel is col 0 of the new line or frame.
- **Line buffers:** LB1 holds row r-1 and LB2 holds row r-2. Both are read-first and addressed by col. On PixValid with col < LINE_WIDTH:
  - LB2[col] ← LB1[col]
  - LB1[col] ← GryIn
- **Window:** a 3x3 register array. On PixValid it shifts left, and the new right column is {LB2 rd, LB1 rd, GryIn}.
- **Kernel:** weights [1 2 1; 2 4 2; 1 2 1].
  - Sum is 12 bits unsigned, maximum 4080.
  - GryOut = sum[11:4], truncated with no rounding.
- **Output position:** the input pixel at (r, c) produces the output for centre (r-1, c-1).
- **Border:** GryOut = 0 with OutValid = 1 when any of these holds at input time:
  - r < 2
  - c < 2
  - c ≥ LINE_WIDTH (overflow pixel; the line buffers are not written)
- **Unconsumed pixels:** the last row and last column of a frame are never emitted as centres.
- **Idle cycles:** a cycle without PixValid changes no window, counter or buffer state. Bubbles do not alter results.
- **Reset:**
  - GryOut = 0, OutValid = 0, col = 0, row = 0, window and sync registers 0.
  - Line buffer contents are not reset. Stale data is masked by the row < 2 rule.
- **Reset mid-frame:** the next PixValid is treated as (0, 0).

## Timing
- **Latency:** 2 clocks from PixValid to OutValid.
  - Cycle 1: line buffer read and window shift.
  - Cycle 2: adder tree and output register.
- **Throughput:** OutValid is PixValid delayed by exactly 2 clocks, with no back-pressure. Throughput is one pixel per clock.
- **Border-flag alignment:** the border flag is computed from col/row at input and delayed 2 cycles alongside the data.
- **Overlap:** a sync edge during the 2-cycle flush does not corrupt in-flight outputs.
- **RST precedence:** RST asserted overrides everything in the same cycle. OutValid is 0 in the cycle after RST is sampled high, and stays 0 until 2 cycles after the first PixValid following reset.

## Structure
- Package filter_pkg holds:
  - PIX_W = 8
  - KSUM_W = 12
  - the kernel weight constants
  - a pixel typedef (8-bit unsigned), shared with the other chain stages.
- Sub-module line_buffer: single-port read-first RAM, depth LINE_WIDTH × 8, with inputs addr/we/din and output dout. It is instantiated twice.
- Counters, sync edge detect, window, adder tree and output registers live in grey_blur3x3.

## Test plan
- **Flat frame:** 8x8 of all 100 with LINE_WIDTH=8.
  - Interior centres (r,c ≥ 1 and ≤ 6) give GryOut = 100.
  - Border outputs give 0.
  - Latency is 2 clocks.
- **Impulse:** value 160 at (5,5) on a zero frame. Required outputs:
  - centre (5,5) = 40
  - (4,5), (5,4), (6,5), (5,6) = 20
  - diagonals (4,4), (4,6), (6,4), (6,6) = 10
  - all others 0
- **Saturation:** all 255 gives interior 255 (sum 4080 → 255).
- **Bubbles:** the flat and impulse frames with PixValid randomly deasserted 50% of cycles produce an output sequence identical to the gapless case.
- **Overflow:** a line of LINE_WIDTH+3 pixels gives the 3 extra outputs = 0. The next line's col restarts at 0 and the buffers are unaffected.
- **Reset and same-cycle sync:**
  - RST mid-row 4 gives outputs 0/invalid for the following 2 rows, then correct blur.
  - HSync edge coincident with PixValid: that pixel is col 0.
